// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the register file, decode and issue.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    // Hardwired-zero register x0
    localparam reg_addr_t X0_ADDR = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and allocate bundle of the multi-port register file.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic [NREGS-1:0]       busy_vec;

    // Datapath / issue side
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    // Register file side
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: write retirement clears, allocation sets, allocation wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next scoreboard: clears first, then the alloc overrides; x0 never busy
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[AW'(X0_ADDR)] = 1'b0;
    end

    // Scoreboard flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional bypass and busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned NREGS      = NREGS_DEF,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_INDEX = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;

    // Write-priority merge: later (higher-index) ports overwrite earlier ones
    always_comb begin
        regs_d = regs_q;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en[w]) begin
                regs_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
            end
        end
        regs_d[AW'(X0_ADDR)] = '0;
    end

    // Register storage; reset contents are either zero or the register index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NUM_WR (NUM_WR),
        .AW     (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .busy_vec   (busy_q)
    );

    assign bus.busy_vec = busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
        logic            wr_hit;
        logic            alloc_hit;

        assign addr = bus.rd_addr[p*AW +: AW];

        // Read mux; bypass is held off during reset so reads show reset contents
        always_comb begin
            data      = regs_q[addr];
            busy      = busy_q[addr];
            wr_hit    = 1'b0;
            alloc_hit = bus.alloc_en && (bus.alloc_addr == addr);
            if ((BYPASS != 0) && rst_n) begin
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (bus.wr_en[w] && (bus.wr_addr[w*AW +: AW] == addr)) begin
                        data   = bus.wr_data[w*XLEN +: XLEN];
                        wr_hit = 1'b1;
                    end
                end
            end
            if (wr_hit && !alloc_hit) begin
                busy = 1'b0;
            end
            if (addr == AW'(X0_ADDR)) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign bus.rd_data[p*XLEN +: XLEN] = data;
        assign bus.rd_busy[p]              = busy;
    end

endmodule
